// File: rtl/l2_flush_ctrl_pkg.sv
// rtl/l2_flush_ctrl_pkg.sv - shared geometry constants and flush FSM state type
package l2_flush_ctrl_pkg;

  localparam int L2_SETS      = 4;
  localparam int L2_WAYS      = 2;
  localparam int L2_SET_BITS  = 2;
  localparam int L2_WAY_BITS  = 1;
  localparam int N_MSHR       = 4;
  localparam int MSHR_BITS_P1 = 3;
  localparam int EVICT_BITS   = L2_SET_BITS + L2_WAY_BITS + 1;

  localparam logic [L2_SET_BITS:0]    SET_LAST  = (L2_SET_BITS+1)'(L2_SETS - 1);
  localparam logic [L2_WAY_BITS:0]    WAY_LAST  = (L2_WAY_BITS+1)'(L2_WAYS - 1);
  localparam logic [EVICT_BITS-1:0]   EVICT_MAX = EVICT_BITS'(L2_SETS * L2_WAYS);
  localparam logic [MSHR_BITS_P1-1:0] MSHR_ALL  = MSHR_BITS_P1'(N_MSHR);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ADVANCE,
    DRAIN,
    DONE
  } flush_state_e;

endpackage

// File: rtl/l2_flush_walker.sv
// rtl/l2_flush_walker.sv - set-major set/way walk counter with clear, increment and terminal flag
module l2_flush_walker
  import l2_flush_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   inc,
  output logic [L2_SET_BITS-1:0] set_idx,
  output logic [L2_WAY_BITS-1:0] way_idx,
  output logic                   last
);

  // One extra bit on each counter so the post-terminal value never aliases line (0,0).
  logic [L2_SET_BITS:0] set_q;
  logic [L2_WAY_BITS:0] way_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      set_q <= '0;
      way_q <= '0;
    end else if (clr) begin
      set_q <= '0;
      way_q <= '0;
    end else if (inc) begin
      if (way_q == WAY_LAST) begin
        way_q <= '0;
        set_q <= set_q + 1'b1;
      end else begin
        way_q <= way_q + 1'b1;
      end
    end
  end

  assign last    = (set_q == SET_LAST) && (way_q == WAY_LAST);
  assign set_idx = set_q[L2_SET_BITS-1:0];
  assign way_idx = way_q[L2_WAY_BITS-1:0];

endmodule

// File: rtl/l2_flush_ctrl.sv
// rtl/l2_flush_ctrl.sv - whole-L2 flush sequencer: one probe per line, evict count, MSHR drain
module l2_flush_ctrl
  import l2_flush_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_req_valid,
  output logic                    flush_req_ready,
  output logic                    probe_valid,
  input  logic                    probe_ready,
  output logic [L2_SET_BITS-1:0]  probe_set,
  output logic [L2_WAY_BITS-1:0]  probe_way,
  input  logic                    probe_resp_valid,
  input  logic                    probe_resp_evict,
  input  logic [MSHR_BITS_P1-1:0] mshr_cnt,
  output logic                    busy,
  output logic                    flush_done,
  output logic [EVICT_BITS-1:0]   evict_cnt
);

  flush_state_e state_q, state_d;
  logic         probe_valid_d;
  logic         accept;
  logic         walk_last;

  assign accept = (state_q == IDLE) && flush_req_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush_req_valid) state_d = ISSUE;
      ISSUE:   if (probe_valid && probe_ready) state_d = WAIT;
      WAIT:    if (probe_resp_valid) state_d = ADVANCE;
      ADVANCE: state_d = walk_last ? DRAIN : ISSUE;
      DRAIN:   if (mshr_cnt == MSHR_ALL) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Valid is sticky until the handshake; a new probe needs a free MSHR to start.
    probe_valid_d = (state_d == ISSUE) && (probe_valid || (mshr_cnt != '0));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      probe_valid <= 1'b0;
      busy        <= 1'b0;
      evict_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      probe_valid <= probe_valid_d;
      busy        <= (state_d != IDLE);
      if (accept) begin
        evict_cnt <= '0;
      end else if ((state_q == WAIT) && probe_resp_valid && probe_resp_evict &&
                   (evict_cnt != EVICT_MAX)) begin
        evict_cnt <= evict_cnt + 1'b1;
      end
    end
  end

  assign flush_req_ready = ~busy;
  assign flush_done      = (state_q == DONE);

  l2_flush_walker u_walker (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .inc     (state_q == ADVANCE),
    .set_idx (probe_set),
    .way_idx (probe_way),
    .last    (walk_last)
  );

endmodule

// File: tb/tb_l2_flush_ctrl.sv
// tb/tb_l2_flush_ctrl.sv - directed self-checking bench for l2_flush_ctrl
module tb_l2_flush_ctrl;
  import l2_flush_ctrl_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    flush_req_valid = 1'b0;
  logic                    flush_req_ready;
  logic                    probe_valid;
  logic                    probe_ready = 1'b1;
  logic [L2_SET_BITS-1:0]  probe_set;
  logic [L2_WAY_BITS-1:0]  probe_way;
  logic                    probe_resp_valid = 1'b0;
  logic                    probe_resp_evict = 1'b0;
  logic [MSHR_BITS_P1-1:0] mshr_cnt = MSHR_BITS_P1'(N_MSHR);
  logic                    busy;
  logic                    flush_done;
  logic [EVICT_BITS-1:0]   evict_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l2_flush_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .flush_req_valid  (flush_req_valid),
    .flush_req_ready  (flush_req_ready),
    .probe_valid      (probe_valid),
    .probe_ready      (probe_ready),
    .probe_set        (probe_set),
    .probe_way        (probe_way),
    .probe_resp_valid (probe_resp_valid),
    .probe_resp_evict (probe_resp_evict),
    .mshr_cnt         (mshr_cnt),
    .busy             (busy),
    .flush_done       (flush_done),
    .evict_cnt        (evict_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_probe_valid"}, 32'(probe_valid), 0);
    chk({tag, "_flush_done"}, 32'(flush_done), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ready"}, 32'(flush_req_ready), 1);
    chk({tag, "_evict_cnt"}, 32'(evict_cnt), 0);
    chk({tag, "_probe_set"}, 32'(probe_set), 0);
    chk({tag, "_probe_way"}, 32'(probe_way), 0);
  endtask

  task automatic start_flush();
    flush_req_valid = 1'b1;
    step();
    flush_req_valid = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_ready", 32'(flush_req_ready), 0);
  endtask

  // Wait for the probe, optionally stall it (dropping mshr_cnt meanwhile), then respond one cycle later.
  task automatic serve_line(input int s, input int w, input logic ev, input int stall);
    int n;
    logic [MSHR_BITS_P1-1:0] m_save;
    probe_ready = (stall == 0);
    n = 0;
    while (probe_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("probe_seen", 32'(probe_valid), 1);
    chk("probe_set", 32'(probe_set), s);
    chk("probe_way", 32'(probe_way), w);
    m_save = mshr_cnt;
    for (int i = 0; i < stall; i++) begin
      if (i == 0) mshr_cnt = '0;
      step();
      chk("stall_valid", 32'(probe_valid), 1);
      chk("stall_set", 32'(probe_set), s);
      chk("stall_way", 32'(probe_way), w);
    end
    mshr_cnt = m_save;
    probe_ready = 1'b1;
    step();
    chk("single_handshake", 32'(probe_valid), 0);
    probe_resp_valid = 1'b1;
    probe_resp_evict = ev;
    step();
    probe_resp_valid = 1'b0;
    probe_resp_evict = 1'b0;
  endtask

  task automatic wait_done(input int exp_evict);
    int n;
    n = 0;
    while (flush_done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("done_seen", 32'(flush_done), 1);
    chk("done_evict_cnt", 32'(evict_cnt), exp_evict);
    step();
    chk("done_one_cycle", 32'(flush_done), 0);
    chk("done_idle_busy", 32'(busy), 0);
    chk("done_idle_ready", 32'(flush_req_ready), 1);
    chk("done_evict_hold", 32'(evict_cnt), exp_evict);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) step();
    chk_reset_outputs("reset");
    rst = 1'b1;
    step();

    // Clean flush: 8 probes set-major, no evictions
    start_flush();
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 2; w++)
        serve_line(s, w, 1'b0, 0);
    wait_done(0);

    // Evict on every odd way; a request while busy is refused
    start_flush();
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 2; w++) begin
        if (s == 1 && w == 1) begin
          flush_req_valid = 1'b1;
          step();
          chk("busy_req_ready", 32'(flush_req_ready), 0);
          flush_req_valid = 1'b0;
        end
        serve_line(s, w, (w == 1), 0);
      end
    wait_done(4);
    repeat (3) step();
    chk("evict_hold_idle", 32'(evict_cnt), 4);

    // No free MSHR for 5 ISSUE cycles, stray response ignored, then stall and drain
    mshr_cnt = '0;
    start_flush();
    chk("evict_cleared", 32'(evict_cnt), 0);
    for (int i = 0; i < 5; i++) begin
      chk("no_mshr_valid", 32'(probe_valid), 0);
      probe_resp_valid = (i == 1);
      probe_resp_evict = (i == 1);
      if (i == 4) mshr_cnt = 3'd1;
      step();
    end
    chk("mshr_issue_valid", 32'(probe_valid), 1);
    chk("stray_resp_evict", 32'(evict_cnt), 0);
    serve_line(0, 0, 1'b0, 0);
    serve_line(0, 1, 1'b0, 3);
    mshr_cnt = MSHR_BITS_P1'(N_MSHR - 2);
    for (int s = 1; s < 4; s++)
      for (int w = 0; w < 2; w++)
        serve_line(s, w, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drain_hold_done", 32'(flush_done), 0);
      chk("drain_hold_busy", 32'(busy), 1);
    end
    mshr_cnt = MSHR_BITS_P1'(N_MSHR);
    step();
    chk("drain_release_done", 32'(flush_done), 1);
    step();
    chk("drain_done_pulse", 32'(flush_done), 0);
    chk("drain_idle_busy", 32'(busy), 0);

    // Reset while waiting on line (2,1), then restart from (0,0)
    start_flush();
    for (int l = 0; l < 5; l++)
      serve_line(l / 2, l % 2, 1'b1, 0);
    step();
    chk("rst_line_set", 32'(probe_set), 2);
    chk("rst_line_way", 32'(probe_way), 1);
    step();
    chk("rst_wait_valid", 32'(probe_valid), 0);
    chk("rst_pre_evict", 32'(evict_cnt), 5);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midflush_reset");
    step();
    chk("midflush_no_done", 32'(flush_done), 0);
    rst = 1'b1;
    step();
    start_flush();
    for (int s = 0; s < 4; s++)
      for (int w = 0; w < 2; w++)
        serve_line(s, w, 1'b0, 0);
    wait_done(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_flush_ctrl.md
L2_FLUSH_CTRL -- requirements
Module: l2_flush_ctrl

Interface
REQ-001 The block SHALL use reset rst, asynchronous, active-low, and clock clk.
REQ-002 Port list, one per line:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- flush_req_valid  in  1  flush command offered
- flush_req_ready  out  1  command accepted (high only in IDLE)
- probe_valid  out  1  line flush probe issued to the L2 pipeline
- probe_ready  in  1  pipeline accepts the probe
- probe_set  out  L2_SET_BITS  set index of the probe
- probe_way  out  L2_WAY_BITS  way index of the probe
- probe_resp_valid  in  1  one-cycle pulse: probe result returned
- probe_resp_evict  in  1  qualified by probe_resp_valid: line needs writeback; one MSHR consumed
- mshr_cnt  in  MSHR_BITS_P1  free MSHR entries (N_MSHR = all free)
- busy  out  1  flush in progress (any state except IDLE)
- flush_done  out  1  one-cycle completion pulse
- evict_cnt  out  L2_SET_BITS+L2_WAY_BITS+1  evictions in the last/current flush

Function
REQ-003 The FSM SHALL have the states IDLE, ISSUE, WAIT, ADVANCE, DRAIN and DONE.
REQ-004 IDLE: flush_req_ready=1; on flush_req_valid the FSM SHALL go to ISSUE, clear the set/way counters and clear evict_cnt.
REQ-005 ISSUE: probe_valid SHALL be asserted only while mshr_cnt != 0; with mshr_cnt==0, probe_valid=0 and the FSM SHALL hold.
REQ-006 ISSUE: probe_valid&&probe_ready SHALL move the FSM to WAIT; probe_set/probe_way SHALL stay stable while probe_valid=1 and probe_ready=0.
REQ-007 probe_valid, once asserted, SHALL not deassert before the handshake, even if mshr_cnt drops to 0 meanwhile.
REQ-008 WAIT: on probe_resp_valid, evict_cnt SHALL increment if probe_resp_evict=1, and the FSM SHALL go to ADVANCE; probe_resp_valid in any other state SHALL be ignored.
REQ-009 ADVANCE: way SHALL increment. At way==L2_WAYS-1 the way SHALL wrap to 0 and the set SHALL increment.
REQ-010 ADVANCE: at set==L2_SETS-1 together with way==L2_WAYS-1, the FSM SHALL go to DRAIN; otherwise it SHALL go to ISSUE.
REQ-011 Per-line latency SHALL be a minimum of 3 cycles (ISSUE, WAIT, ADVANCE), with exactly one probe outstanding at any time.
REQ-012 Set and way counters SHALL be one bit wider than the index to make terminal detection explicit; probe_set/probe_way SHALL be the low bits.
REQ-013 DRAIN: the FSM SHALL hold until mshr_cnt==N_MSHR, then go to DONE.
REQ-014 DONE: flush_done=1 for exactly one cycle, then the FSM SHALL return to IDLE; evict_cnt SHALL hold its value until the next accepted command.
REQ-015 flush_req_valid while busy SHALL be ignored (ready=0); no queuing.
REQ-016 evict_cnt SHALL saturate at L2_SETS*L2_WAYS and never wrap.
REQ-017 busy SHALL be registered and equal (state != IDLE).

Reset
REQ-018 On rst low the block SHALL return to IDLE immediately, including mid-flush, with no completion pulse.
REQ-019 Reset values SHALL be: probe_valid=0, flush_done=0, busy=0, flush_req_ready=1, set/way counters=0, evict_cnt=0, probe_set=0, probe_way=0.

Structure
REQ-020 L2_SETS, L2_WAYS, L2_SET_BITS, L2_WAY_BITS, N_MSHR and MSHR_BITS_P1 SHALL come from the shared consts/types package.
REQ-021 The FSM state enum SHALL live in the shared types package.
REQ-022 The block SHALL have one sub-module, l2_flush_walker: a set/way counter with clear, increment and a terminal flag.

Verification
REQ-023 Directed scenarios the bench SHALL cover:
- L2_SETS=4, L2_WAYS=2, probe_ready=1, responses 1 cycle after the probe, no evicts, mshr_cnt=N_MSHR -> 8 probes in set-major order (0,0),(0,1),(1,0)...; flush_done one pulse; evict_cnt=0.
- Same, with probe_resp_evict=1 on every odd way -> evict_cnt=4.
- mshr_cnt=0 during ISSUE for 5 cycles -> probe_valid low for those 5 cycles; probe issues the cycle after mshr_cnt becomes 1.
- probe_ready=0 for 3 cycles -> probe_set/probe_way stable; a single handshake.
- Last line done with mshr_cnt=N_MSHR-2 -> DRAIN holds; flush_done 1 cycle after mshr_cnt returns to N_MSHR.
- rst asserted in WAIT at line (2,1) -> IDLE with all outputs at reset values; a new command restarts at (0,0).
